// File: rtl/crc8_frame_check.sv
// Receive-side CRC-8 frame checker: shifts each byte MSB-first through a bit-serial
// LFSR and reports the residue check when the byte flagged as last has been shifted.
module crc8_frame_check #(
   parameter logic [7:0] POLY = 8'h07,
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [7:0] crc_out,
   output logic       done,
   output logic       crc_ok,
   output logic       crc_err,
   output logic       len_err,
   output logic [1:0] dbg_state_o
);

   // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
   // in_ready is high only in IDLE, and in_data/in_last are ignored otherwise.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0] state_q, state_d;
   logic [7:0] crc_q, crc_d;
   logic [7:0] shreg_q, shreg_d;
   logic       last_q, last_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic       fb;
   logic       frame_ok;

   assign fb = crc_q[7] ^ shreg_q[7];

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      shreg_d = shreg_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               shreg_d = in_data;
               last_d  = in_last;
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
               bit_d   = 3'd0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            crc_d   = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
            shreg_d = {shreg_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = last_q ? S_DONE : S_IDLE;
         end
         S_DONE: begin
            crc_d   = INIT;
            cnt_d   = 8'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Abort wins over every transition, including the result cycle.
      if (clr) begin
         state_d = S_IDLE;
         crc_d   = INIT;
         cnt_d   = 8'd0;
         bit_d   = 3'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         crc_q   <= INIT;
         shreg_q <= 8'h00;
         last_q  <= 1'b0;
         cnt_q   <= 8'd0;
         bit_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         shreg_q <= shreg_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
      end
   end

   assign frame_ok    = (crc_q == 8'h00) && (cnt_q >= 8'd2);
   assign in_ready    = (state_q == S_IDLE);
   assign done        = (state_q == S_DONE) && !clr;
   assign crc_ok      = done && frame_ok;
   assign crc_err     = done && !frame_ok;
   assign len_err     = done && (cnt_q < 8'd2);
   assign crc_out     = crc_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_crc8_frame_check.sv
// Bench for crc8_frame_check: directed and random frames checked against a
// byte-wise CRC-8 division model and an expected-result queue.
module tb_crc8_frame_check;

   typedef logic [7:0] byte_q_t[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [7:0] crc_out;
   logic       done, crc_ok, crc_err, len_err;
   logic [1:0] dbg_state;

   int n_vec = 0;
   int n_err = 0;
   logic [2:0] exp_q[$];

   crc8_frame_check dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .crc_out(crc_out), .done(done),
      .crc_ok(crc_ok), .crc_err(crc_err), .len_err(len_err),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   // Remainder of (message * x^8) mod x^8+x^2+x+1, one byte folded in at a time.
   function automatic logic [7:0] crc8_ref(input byte_q_t q);
      logic [7:0] r;
      r = 8'h00;
      foreach (q[i]) begin
         r = r ^ q[i];
         for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic accept_byte(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      while (!in_ready && n < 40) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         in_last  = 1'($urandom);
         @(negedge clk);
         n++;
      end
      chk("accept_wait", {7'd0, in_ready}, 8'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(posedge clk);
      @(negedge clk);
      in_data = 8'($urandom);
      in_last = 1'($urandom);
      chk("ready_low_after_accept", {7'd0, in_ready}, 8'd0);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_data = 8'($urandom);
         @(negedge clk);
         chk("idle_no_done", {7'd0, done}, 8'd0);
      end
   endtask

   task automatic send_frame(input byte_q_t f, input int abort_at, input bit clr_done);
      byte_q_t    pre;
      logic [7:0] res;
      logic       ok, le;
      logic [2:0] e;
      pre = {};
      le  = (f.size() < 2);
      res = crc8_ref(f);
      ok  = !le && (res == 8'h00);
      if (abort_at < 0 && !clr_done) exp_q.push_back({ok, !ok, le});
      for (int i = 0; i < f.size(); i++) begin
         accept_byte(f[i], i == f.size() - 1);
         pre.push_back(f[i]);
         if (i == abort_at) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            in_valid = 1'b0;
            chk("clr_crc_init", crc_out, 8'h00);
            chk("clr_ready", {7'd0, in_ready}, 8'd1);
            chk("clr_no_done", {7'd0, done}, 8'd0);
            return;
         end
         repeat (7) @(posedge clk);
         @(negedge clk);
         chk("busy_during_shift", {7'd0, in_ready}, 8'd0);
         @(posedge clk);
         @(negedge clk);
         chk("crc_after_byte", crc_out, crc8_ref(pre));
         if (i < f.size() - 1) begin
            chk("ready_after_9", {7'd0, in_ready}, 8'd1);
            chk("no_done_mid", {7'd0, done}, 8'd0);
         end else if (clr_done) begin
            clr = 1'b1;
            #1;
            chk("clr_done_done", {7'd0, done}, 8'd0);
            chk("clr_done_flags", {5'd0, crc_ok, crc_err, len_err}, 8'd0);
            @(posedge clk);
            #1 clr = 1'b0;
            @(negedge clk);
            chk("clr_done_ready", {7'd0, in_ready}, 8'd1);
            chk("clr_done_crc", crc_out, 8'h00);
         end else begin
            chk("done_pulse", {7'd0, done}, 8'd1);
            chk("ready_in_done", {7'd0, in_ready}, 8'd0);
            e = exp_q.pop_front();
            chk("result_flags", {5'd0, crc_ok, crc_err, len_err}, {5'd0, e});
            @(posedge clk);
            @(negedge clk);
            chk("done_one_cycle", {7'd0, done}, 8'd0);
            chk("ready_after_done", {7'd0, in_ready}, 8'd1);
            chk("crc_reinit", crc_out, 8'h00);
         end
      end
   endtask

   byte_q_t good, bad, one, zz, rnd;
   int      plen;

   initial begin
      good = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
      bad  = good;
      bad[4] = 8'h34;
      one  = {8'h00};
      zz   = {8'h00, 8'h00};

      #12;
      chk("rst_ready", {7'd0, in_ready}, 8'd1);
      chk("rst_crc", crc_out, 8'h00);
      chk("rst_flags", {4'd0, done, crc_ok, crc_err, len_err}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {7'd0, in_ready}, 8'd1);

      chk("ref_check_value", crc8_ref(good[0:8]), 8'hF4);
      send_frame(good, -1, 1'b0);
      idle(2);
      send_frame(bad, -1, 1'b0);
      idle(1);
      send_frame(one, -1, 1'b0);
      idle(1);

      // Back-to-back frames with in_valid held high throughout.
      send_frame(zz, -1, 1'b0);
      send_frame(good, -1, 1'b0);
      idle(2);

      // Abort in the 4th shift cycle of byte 33, then resend.
      send_frame(good, 2, 1'b0);
      idle(3);
      send_frame(good, -1, 1'b0);
      idle(1);

      send_frame(good, -1, 1'b1);
      idle(1);

      // Asynchronous reset between edges in the middle of a frame.
      accept_byte(8'h31, 1'b0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("async_rst_ready", {7'd0, in_ready}, 8'd1);
      chk("async_rst_crc", crc_out, 8'h00);
      chk("async_rst_flags", {4'd0, done, crc_ok, crc_err, len_err}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      send_frame(good, -1, 1'b0);
      idle(1);

      for (int t = 0; t < 24; t++) begin
         rnd  = {};
         plen = $urandom_range(0, 6);
         for (int i = 0; i < plen; i++) rnd.push_back(8'($urandom));
         rnd.push_back(crc8_ref(rnd));
         if ($urandom_range(0, 2) == 0) begin
            int idx;
            idx = $urandom_range(0, rnd.size() - 1);
            rnd[idx] = rnd[idx] ^ (8'h01 << $urandom_range(0, 7));
         end
         send_frame(rnd, -1, 1'b0);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(2);

      chk("exp_q_drained", 8'(exp_q.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/crc8_frame_check.md
# crc8_frame_check

Receive-side CRC-8 checker paired with the bit-serial CRC-8 byte generator: accepts a framed byte stream whose final byte is the transmitted CRC-8, runs every byte MSB-first through a bit-serial CRC-8 LFSR, and reports pass/fail when the frame ends. It sits between the byte-level link receiver and the packet consumer, and shares polynomial and bit-order conventions with the transmit-side generator.

## Interface
- POLY, 8'h07, CRC-8 generator polynomial, x^8 term implicit, non-reflected
- INIT, 8'h00, LFSR value at reset, after `clr`, and after each completed frame
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort: drop the current frame, LFSR := INIT, go to IDLE, no result pulse
- in_data  in  8  received byte
- in_valid  in  1  in_data/in_last valid
- in_last  in  1  byte is the final byte (the CRC byte) of the frame
- in_ready  out  1  checker can accept a byte this cycle
- crc_out  out  8  current LFSR contents
- done  out  1  one-cycle pulse: frame result valid
- crc_ok  out  1  valid with done: residue == 0 and length >= 2
- crc_err  out  1  valid with done: inverse of crc_ok
- len_err  out  1  valid with done: frame was shorter than 2 bytes

## Operation
- The already-decided interface is one clock and an asynchronous active-low reset: `clk` and `rst_n`.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch in_data into an 8-bit shift register, latch in_last into `last_q`, increment the byte count (8-bit, saturating at 255), clear the bit counter, and go to SHIFT.
- SHIFT: in_ready=0. On each cycle, b = shreg[7], fb = crc[7]^b, crc := {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00), shreg := shreg<<1, and the 3-bit counter increments. After the 8th shift (counter==7), go to DONE if last_q, else go to IDLE.
- DONE: drive done=1 for exactly this cycle with crc_ok = (crc==0) && (count>=2), len_err = (count<2), and crc_err = !crc_ok. On the next edge, crc := INIT, count := 0, go to IDLE.
- Check by residue: with xorout 0, the CRC over payload plus the appended CRC byte is 8'h00 for any INIT.
- Outside DONE, done, crc_ok, crc_err, and len_err are 0.
- clr has priority over all state transitions, including DONE; if clr is asserted in DONE, done is still 0.
- in_valid without in_ready is ignored, and in_data may change freely while in_ready is low.

## Timing
- Reset values: state=IDLE, crc=INIT, crc_out=INIT, in_ready=1, done=crc_ok=crc_err=len_err=0, count=0.
- Per byte: accept edge T, shifts on edges T+1..T+8. A non-last byte reasserts in_ready in cycle T+9, giving 9 cycles per byte.
- For the last byte, done is high in cycle T+9, and in_ready rises in cycle T+10.
- crc_out is registered and reflects the LFSR after each shift edge.
- rst_n asserted mid-frame clears state immediately (asynchronously) to the reset values.
- A clr edge returns in_ready=1 in the next cycle.

## Test plan
- Frame 31 32 33 34 35 36 37 38 39 F4 (last on F4), POLY=07, INIT=00: crc_out=F4 after byte 39. In the DONE cycle, done=1, crc_ok=1, crc_err=0, len_err=0, and crc_out=00.
- Same frame with byte 35 changed to 34: done=1, crc_ok=0, crc_err=1, len_err=0.
- Single byte 00 with in_last=1: done=1, len_err=1, crc_ok=0, crc_err=1.
- Back-to-back frames 00 00 then 31 32 33 34 35 36 37 38 39 F4, with in_valid held high: both report crc_ok, in_ready shows the 9-cycle spacing, and the LFSR restarts at INIT for the second frame.
- clr asserted in the 4th shift cycle of byte 33 of the check frame: no done pulse, crc_out=INIT next cycle. Resending the full frame then gives crc_ok=1.
- rst_n pulsed low mid-frame, asynchronously between edges: all outputs take reset values immediately. A subsequent good frame gives crc_ok=1.
